// File: rtl/ex_mem_wb_datapath_pkg.sv
// Shared types for the EX/MEM/WB back half of the RV32I pipeline.
// ALU op codes, forward selects, opcodes and the EX/MEM record.
package ex_mem_wb_datapath_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_IDEX  = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10,
    FWD_IDEX3 = 2'b11
  } fwd_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic        is_valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic [31:0] result;
    logic [31:0] s_data;
  } ex_mem_t;

  function automatic logic [31:0] fwd(
    input logic [1:0]  sel,
    input logic [31:0] idex,
    input logic [31:0] exmem,
    input logic [31:0] memwb
  );
    case (fwd_e'(sel))
      FWD_EXMEM: fwd = exmem;
      FWD_MEMWB: fwd = memwb;
      default:   fwd = idex;
    endcase
  endfunction

endpackage

// File: rtl/ex_mem_wb_datapath_alu.sv
// RV32I EX-stage ALU: result plus Z/N/C/V flags.
// Flags exist only when ALU_FLAGS_EN is defined; otherwise tied to 0.
module alu
  import ex_mem_wb_datapath_pkg::*;
(
  input  logic [3:0]  alu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        z,
  output logic        n,
  output logic        c,
  output logic        v
);

  logic [4:0]  shamt;
  logic [32:0] sum;
  logic [32:0] diff;

  assign shamt = b[4:0];
  assign sum   = {1'b0, a} + {1'b0, b};
  // carry out of A + ~B + 1: set means no borrow
  assign diff  = {1'b0, a} + {1'b0, ~b} + 33'd1;

  always_comb begin
    result = 32'd0;
    case (alu_op_e'(alu_op))
      ALU_ADD:  result = sum[31:0];
      ALU_SUB:  result = diff[31:0];
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'd0, a < b};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = 32'd0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  always_comb begin
    z = (result == 32'd0);
    n = result[31];
    c = 1'b0;
    v = 1'b0;
    case (alu_op_e'(alu_op))
      ALU_ADD: begin
        c = sum[32];
        v = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      ALU_SUB: begin
        c = diff[32];
        v = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      default: ;
    endcase
  end
`else
  logic unused;
  assign unused = sum[32] ^ diff[32];
  assign z = 1'b0;
  assign n = 1'b0;
  assign c = 1'b0;
  assign v = 1'b0;
`endif

endmodule

// File: rtl/ex_mem_wb_datapath.sv
// EX-stage forwarding + ALU, EX/MEM register and write-back mux.
// Optional macro ALU_FLAGS_EN enables the Z/N/C/V flag logic.
module ex_mem_wb_datapath
  import ex_mem_wb_datapath_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        IS_FORW_ON,
  input  logic [3:0]  alu_op,
  input  logic [6:0]  op,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [31:0] s_data,
  input  logic [1:0]  forwA,
  input  logic [1:0]  forwB,
  input  logic [31:0] exmem_result,
  input  logic [31:0] memwb_result,
  input  logic        ex_isValid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_instr,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_reg_write,
  output logic [31:0] result,
  output logic [31:0] sData,
  output logic        Z,
  output logic        N,
  output logic        C,
  output logic        V,
  output logic        mem_isValid,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_instr,
  output logic [4:0]  mem_rd,
  output logic        mem_mem_read,
  output logic        mem_mem_write,
  output logic        mem_reg_write,
  output logic [31:0] mem_result,
  output logic [31:0] mem_sData,
  input  logic        wb_mem_read,
  input  logic [31:0] wb_alu,
  input  logic [31:0] wb_mem,
  output logic [31:0] wb_data
);

  logic [1:0]  sel_a;
  logic [1:0]  sel_b;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] fwd_b;
  logic        b_fwd_ok;
  ex_mem_t     ex_mem_d;
  ex_mem_t     ex_mem_q;

  assign sel_a = IS_FORW_ON ? forwA : FWD_IDEX;
  assign sel_b = IS_FORW_ON ? forwB : FWD_IDEX;

  // only register-register ops forward B; others carry an immediate
  assign b_fwd_ok = (op == OP_R) || (op == OP_BRANCH);

  assign op_a  = fwd(sel_a, data1, exmem_result, memwb_result);
  assign fwd_b = fwd(sel_b, data2, exmem_result, memwb_result);
  assign op_b  = b_fwd_ok ? fwd_b : data2;

  assign sData = (op == OP_STORE)
               ? fwd(sel_b, s_data, exmem_result, memwb_result)
               : s_data;

  alu u_alu (
    .alu_op (alu_op),
    .a      (op_a),
    .b      (op_b),
    .result (result),
    .z      (Z),
    .n      (N),
    .c      (C),
    .v      (V)
  );

  always_comb begin
    ex_mem_d           = '0;
    ex_mem_d.is_valid  = ex_isValid;
    ex_mem_d.pc        = ex_pc;
    ex_mem_d.instr     = ex_instr;
    ex_mem_d.rd        = ex_rd;
    ex_mem_d.mem_read  = ex_mem_read;
    ex_mem_d.mem_write = ex_mem_write;
    ex_mem_d.reg_write = ex_reg_write;
    ex_mem_d.result    = result;
    ex_mem_d.s_data    = sData;
  end

  always_ff @(posedge clk) begin
    if (!reset) ex_mem_q <= '0;
    else        ex_mem_q <= ex_mem_d;
  end

  assign mem_isValid   = ex_mem_q.is_valid;
  assign mem_pc        = ex_mem_q.pc;
  assign mem_instr     = ex_mem_q.instr;
  assign mem_rd        = ex_mem_q.rd;
  assign mem_mem_read  = ex_mem_q.mem_read;
  assign mem_mem_write = ex_mem_q.mem_write;
  assign mem_reg_write = ex_mem_q.reg_write;
  assign mem_result    = ex_mem_q.result;
  assign mem_sData     = ex_mem_q.s_data;

  assign wb_data = wb_mem_read ? wb_mem : wb_alu;

endmodule

// File: tb/tb_ex_mem_wb_datapath.sv
// Directed self-checking bench for ex_mem_wb_datapath.
// Flag expectations follow ALU_FLAGS_EN (all zero when undefined).
module tb_ex_mem_wb_datapath;

`ifdef ALU_FLAGS_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        IS_FORW_ON;
  logic [3:0]  alu_op;
  logic [6:0]  op;
  logic [31:0] data1, data2, s_data;
  logic [1:0]  forwA, forwB;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_isValid;
  logic [31:0] ex_pc, ex_instr;
  logic [4:0]  ex_rd;
  logic        ex_mem_read, ex_mem_write, ex_reg_write;
  logic [31:0] result, sData;
  logic        Z, N, C, V;
  logic        mem_isValid;
  logic [31:0] mem_pc, mem_instr;
  logic [4:0]  mem_rd;
  logic        mem_mem_read, mem_mem_write, mem_reg_write;
  logic [31:0] mem_result, mem_sData;
  logic        wb_mem_read;
  logic [31:0] wb_alu, wb_mem, wb_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mem_wb_datapath dut (
    .clk           (clk),
    .reset         (reset),
    .IS_FORW_ON    (IS_FORW_ON),
    .alu_op        (alu_op),
    .op            (op),
    .data1         (data1),
    .data2         (data2),
    .s_data        (s_data),
    .forwA         (forwA),
    .forwB         (forwB),
    .exmem_result  (exmem_result),
    .memwb_result  (memwb_result),
    .ex_isValid    (ex_isValid),
    .ex_pc         (ex_pc),
    .ex_instr      (ex_instr),
    .ex_rd         (ex_rd),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_reg_write  (ex_reg_write),
    .result        (result),
    .sData         (sData),
    .Z             (Z),
    .N             (N),
    .C             (C),
    .V             (V),
    .mem_isValid   (mem_isValid),
    .mem_pc        (mem_pc),
    .mem_instr     (mem_instr),
    .mem_rd        (mem_rd),
    .mem_mem_read  (mem_mem_read),
    .mem_mem_write (mem_mem_write),
    .mem_reg_write (mem_reg_write),
    .mem_result    (mem_result),
    .mem_sData     (mem_sData),
    .wb_mem_read   (wb_mem_read),
    .wb_alu        (wb_alu),
    .wb_mem        (wb_mem),
    .wb_data       (wb_data)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic [3:0] o, input logic [6:0] opc,
                         input logic [31:0] a, input logic [31:0] b);
    alu_op = o;
    op     = opc;
    data1  = a;
    data2  = b;
    #1;
  endtask

  initial begin
    reset = 1'b0; IS_FORW_ON = 1'b0;
    alu_op = 4'd0; op = 7'b0110011;
    data1 = 32'h11; data2 = 32'h22; s_data = 32'h33;
    forwA = 2'b00; forwB = 2'b00;
    exmem_result = 32'h0; memwb_result = 32'h0;
    ex_isValid = 1'b1; ex_pc = 32'h100; ex_instr = 32'hdead;
    ex_rd = 5'd3; ex_mem_read = 1'b1; ex_mem_write = 1'b1;
    ex_reg_write = 1'b1;
    wb_mem_read = 1'b0; wb_alu = 32'h0; wb_mem = 32'h0;

    tick();
    check("rst_valid", {31'd0, mem_isValid}, 32'd0);
    check("rst_pc", mem_pc, 32'd0);
    check("rst_rd", {27'd0, mem_rd}, 32'd0);
    check("rst_ctl", {29'd0, mem_mem_read, mem_mem_write,
                      mem_reg_write}, 32'd0);
    check("rst_res", mem_result, 32'd0);
    check("rst_sdata", mem_sData, 32'd0);
    tick();
    check("rst_hold_instr", mem_instr, 32'd0);
    reset = 1'b1;

    set_alu(4'd0, 7'b0110011, 32'h7FFFFFFF, 32'd1);
    check("add_ovf", result, 32'h80000000);
    check("add_flags", {28'd0, Z, N, C, V}, {28'd0, 1'b0, FL, 1'b0, FL});

    set_alu(4'd0, 7'b0110011, 32'hFFFFFFFF, 32'd2);
    check("add_carry", result, 32'd1);
    check("add_c_flags", {28'd0, Z, N, C, V},
          {28'd0, 1'b0, 1'b0, FL, 1'b0});

    set_alu(4'd1, 7'b0110011, 32'd5, 32'd5);
    check("sub_zero", result, 32'd0);
    check("sub_flags", {28'd0, Z, N, C, V}, {28'd0, FL, 1'b0, FL, 1'b0});

    set_alu(4'd1, 7'b0110011, 32'h80000000, 32'd1);
    check("sub_ovf", result, 32'h7FFFFFFF);
    check("sub_ovf_fl", {28'd0, Z, N, C, V},
          {28'd0, 1'b0, 1'b0, FL, FL});

    set_alu(4'd3, 7'b0110011, 32'hFFFFFFFF, 32'd1);
    check("slt", result, 32'd1);
    set_alu(4'd4, 7'b0110011, 32'hFFFFFFFF, 32'd1);
    check("sltu", result, 32'd0);
    check("sltu_cv", {30'd0, C, V}, 32'd0);
    set_alu(4'd2, 7'b0110011, 32'h00000003, 32'h00000024);
    check("sll", result, 32'h00000030);
    set_alu(4'd7, 7'b0110011, 32'h80000000, 32'd4);
    check("sra", result, 32'hF8000000);
    set_alu(4'd6, 7'b0110011, 32'h80000000, 32'd4);
    check("srl", result, 32'h08000000);
    set_alu(4'd5, 7'b0110011, 32'hF0F0F0F0, 32'hFF00FF00);
    check("xor", result, 32'h0FF00FF0);
    set_alu(4'd8, 7'b0110011, 32'hF0F0F0F0, 32'h0000FF00);
    check("or", result, 32'hF0F0FFF0);
    set_alu(4'd9, 7'b0110011, 32'hF0F0F0F0, 32'h0000FF00);
    check("and", result, 32'h0000F000);
    set_alu(4'd12, 7'b0110011, 32'h12345678, 32'h1);
    check("op12_zero", result, 32'd0);

    // forwarding on R-type
    IS_FORW_ON = 1'b1; forwA = 2'b01; forwB = 2'b10;
    exmem_result = 32'd10; memwb_result = 32'd3;
    set_alu(4'd0, 7'b0110011, 32'd100, 32'd200);
    check("fwd_r_add", result, 32'd13);
    forwB = 2'b01; #1;
    check("fwd_both_ex", result, 32'd20);
    forwA = 2'b11; forwB = 2'b00; #1;
    check("fwd_sel11", result, 32'd300);
    forwA = 2'b10; forwB = 2'b01;
    set_alu(4'd1, 7'b1100011, 32'd100, 32'd200);
    check("fwd_branch", result, 32'hFFFFFFF9);
    forwA = 2'b01; forwB = 2'b10;
    IS_FORW_ON = 1'b0;
    set_alu(4'd0, 7'b0110011, 32'd100, 32'd200);
    check("fwd_off", result, 32'd300);
    IS_FORW_ON = 1'b1;
    set_alu(4'd0, 7'b0010011, 32'd100, 32'd200);
    check("itype_no_fwdb", result, 32'd210);
    check("itype_sdata", sData, 32'h33);

    // store with forwarded store data
    forwA = 2'b00; forwB = 2'b01;
    exmem_result = 32'h55; s_data = 32'hAA;
    ex_mem_read = 1'b0; ex_mem_write = 1'b1; ex_reg_write = 1'b0;
    ex_rd = 5'd0; ex_pc = 32'h200; ex_instr = 32'h00812023;
    set_alu(4'd0, 7'b0100011, 32'h100, 32'd8);
    check("st_sdata", sData, 32'h55);
    check("st_result", result, 32'h108);
    tick();
    check("st_mem_sdata", mem_sData, 32'h55);
    check("st_mem_res", mem_result, 32'h108);
    check("st_mem_wr", {31'd0, mem_mem_write}, 32'd1);
    check("st_mem_pc", mem_pc, 32'h200);
    check("st_mem_instr", mem_instr, 32'h00812023);
    check("st_mem_valid", {31'd0, mem_isValid}, 32'd1);
    check("st_mem_rw", {31'd0, mem_reg_write}, 32'd0);

    // mid-operation reset
    ex_reg_write = 1'b1; ex_rd = 5'd7; ex_mem_write = 1'b0;
    reset = 1'b0;
    tick();
    check("rst2_rw", {31'd0, mem_reg_write}, 32'd0);
    check("rst2_rd", {27'd0, mem_rd}, 32'd0);
    check("rst2_sdata", mem_sData, 32'd0);
    check("rst2_comb", result, 32'h108);
    reset = 1'b1;
    tick();
    check("rel_rd", {27'd0, mem_rd}, 32'd7);
    check("rel_rw", {31'd0, mem_reg_write}, 32'd1);
    check("rel_res", mem_result, 32'h108);

    wb_mem_read = 1'b1; wb_mem = 32'h1234; wb_alu = 32'h99; #1;
    check("wb_mem", wb_data, 32'h1234);
    wb_mem_read = 1'b0; #1;
    check("wb_alu", wb_data, 32'h99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
